// File: rtl/grid_pkg.sv
// Shared grid dimensions, cell/digit types, controller state encoding and one-hot decode.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package grid_pkg;

    localparam int GRID_ORD  = 3;
    localparam int GRID_LEN  = GRID_ORD * GRID_ORD;
    localparam int GRID_AREA = GRID_LEN * GRID_LEN;
    localparam int IDX_W     = $clog2(GRID_AREA);
    localparam int DIG_W     = $clog2(GRID_LEN + 1);

    typedef logic [IDX_W-1:0] cell_idx_t;
    typedef logic [DIG_W-1:0] digit_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_WAIT,
        ST_FETCH,
        ST_SEND
    } ctrl_state_t;

    // Bit k set gives k+1; anything other than exactly one set bit gives 0.
    function automatic digit_t onehot2bin(input logic [GRID_LEN-1:0] v);
        digit_t      d;
        int unsigned n;
        d = '0;
        n = 0;
        for (int k = 0; k < GRID_LEN; k++) begin
            if (v[k]) begin
                d = digit_t'(k + 1);
                n++;
            end
        end
        return (n == 1) ? d : '0;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Converts a one-hot cell value to its binary digit and flags zero-hot / multi-hot input.
// Latency: combinational.
// Backpressure: none.
module onehot_encoder
    import grid_pkg::*;
(
    input  logic [GRID_LEN-1:0] onehot,
    output logic [DIG_W-1:0]    digit,
    output logic                invalid
);

    assign digit   = onehot2bin(onehot);
    // A legal one-hot value always decodes to a nonzero digit.
    assign invalid = (digit == '0);

endmodule

// File: rtl/grid_solve_ctrl.sv
// Kicks the tile grid, waits for done, then streams every cell as a binary digit in row-major order.
// Latency: grid_start 1 cycle after go; one digit per 2 cycles at best. Optional SOLVE_TIMEOUT_EN bounds WAIT.
// Backpressure: out_digit/out_last/cell_index hold while out_valid && !out_ready; no digit is dropped.
module grid_solve_ctrl
    import grid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    output logic                grid_start,
    input  logic                grid_done_success,
    input  logic                grid_done_failure,
    output logic [IDX_W-1:0]    cell_index,
    input  logic [GRID_LEN-1:0] cell_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIG_W-1:0]    out_digit,
    output logic                out_last,
    output logic                busy,
    output logic                solved,
    output logic                failed,
    output logic                bad_value,
    output logic                timed_out
);

    ctrl_state_t state_q, state_d;
    logic        grid_start_q, grid_start_d;
    logic        out_valid_q, out_valid_d;
    digit_t      out_digit_q, out_digit_d;
    logic        out_last_q, out_last_d;
    cell_idx_t   cell_index_q, cell_index_d;
    logic        busy_q, busy_d;
    logic        solved_q, solved_d;
    logic        failed_q, failed_d;
    logic        bad_value_q, bad_value_d;

    digit_t      enc_digit;
    logic        enc_invalid;

`ifdef SOLVE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timed_out_q, timed_out_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    onehot_encoder u_enc (
        .onehot  (cell_value),
        .digit   (enc_digit),
        .invalid (enc_invalid)
    );

    // Next-state and next-output computation for the run controller.
    always_comb begin
        state_d      = state_q;
        grid_start_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_digit_d  = out_digit_q;
        out_last_d   = out_last_q;
        cell_index_d = cell_index_q;
        busy_d       = busy_q;
        solved_d     = solved_q;
        failed_d     = failed_q;
        bad_value_d  = bad_value_q;
`ifdef SOLVE_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        timed_out_d  = timed_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    solved_d     = 1'b0;
                    failed_d     = 1'b0;
                    bad_value_d  = 1'b0;
`ifdef SOLVE_TIMEOUT_EN
                    timed_out_d  = 1'b0;
`endif
                    grid_start_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_KICK;
                end
            end
            ST_KICK: begin
`ifdef SOLVE_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Failure wins over a coincident success; either beats the timeout.
                if (grid_done_failure) begin
                    failed_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (grid_done_success) begin
                    cell_index_d = '0;
                    state_d      = ST_FETCH;
                end
`ifdef SOLVE_TIMEOUT_EN
                else if (wait_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    failed_d    = 1'b1;
                    timed_out_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TMO_W'(1);
                end
`endif
            end
            ST_FETCH: begin
                out_digit_d = enc_digit;
                out_last_d  = (cell_index_q == cell_idx_t'(GRID_AREA - 1));
                bad_value_d = bad_value_q | enc_invalid;
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        solved_d     = 1'b1;
                        cell_index_d = '0;
                        busy_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        cell_index_d = cell_index_q + IDX_W'(1);
                        state_d      = ST_FETCH;
                    end
                end
            end
            default: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous clear drops any digit in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grid_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_digit_q  <= '0;
            out_last_q   <= 1'b0;
            cell_index_q <= '0;
            busy_q       <= 1'b0;
            solved_q     <= 1'b0;
            failed_q     <= 1'b0;
            bad_value_q  <= 1'b0;
`ifdef SOLVE_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timed_out_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grid_start_q <= grid_start_d;
            out_valid_q  <= out_valid_d;
            out_digit_q  <= out_digit_d;
            out_last_q   <= out_last_d;
            cell_index_q <= cell_index_d;
            busy_q       <= busy_d;
            solved_q     <= solved_d;
            failed_q     <= failed_d;
            bad_value_q  <= bad_value_d;
`ifdef SOLVE_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            timed_out_q  <= timed_out_d;
`endif
        end
    end

    assign grid_start = grid_start_q;
    assign out_valid  = out_valid_q;
    assign out_digit  = out_digit_q;
    assign out_last   = out_last_q;
    assign cell_index = cell_index_q;
    assign busy       = busy_q;
    assign solved     = solved_q;
    assign failed     = failed_q;
    assign bad_value  = bad_value_q;
`ifdef SOLVE_TIMEOUT_EN
    assign timed_out  = timed_out_q;
`else
    assign timed_out  = 1'b0;
`endif

endmodule

// File: tb/tb_grid_solve_ctrl.sv
// Directed bench for grid_solve_ctrl: success stream, failure, backpressure, corrupt cells, reset, timeout.
// Latency: n/a (testbench).
// Backpressure: exercised by stalling out_ready mid-stream.
module tb_grid_solve_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic       success = 1'b0;
    logic       failure = 1'b0;
    logic       out_ready = 1'b0;
    logic       grid_start;
    logic [6:0] cell_index;
    logic [8:0] cell_value;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_last;
    logic       busy, solved, failed, bad_value, timed_out;

    logic [8:0] cells   [81];
    logic [3:0] exp_dig [81];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // External cell mux: combinational lookup of the addressed cell.
    assign cell_value = (cell_index < 7'd81) ? cells[cell_index] : 9'h000;

    grid_solve_ctrl #(.TIMEOUT_CYCLES(50)) dut (
        .clock             (clock),
        .reset             (reset),
        .go                (go),
        .grid_start        (grid_start),
        .grid_done_success (success),
        .grid_done_failure (failure),
        .cell_index        (cell_index),
        .cell_value        (cell_value),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_digit         (out_digit),
        .out_last          (out_last),
        .busy              (busy),
        .solved            (solved),
        .failed            (failed),
        .bad_value         (bad_value),
        .timed_out         (timed_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic init_cells();
        for (int i = 0; i < 81; i++) begin
            cells[i]   = 9'(1 << (i % 9));
            exp_dig[i] = 4'((i % 9) + 1);
        end
    endtask

    // go, KICK, then into WAIT.
    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
    endtask

    // Consume the whole stream, optionally stalling at one cell and pulsing go mid-stream.
    task automatic collect(input string tag, input int stall_cell, input int stall_cycles, input int go_at);
        int acc = 0, cyc = 0, last_hs = -1;
        int gap_bad = 0, dig_bad = 0, idx_bad = 0, last_bad = 0, last_cnt = 0;
        int stable_bad = 0, stall_left = 0, gs_bad = 0;
        bit stall_done = 1'b0, done = 1'b0;
        logic [3:0] held_dig = '0;
        logic [6:0] held_idx = '0;
        while (!done && cyc < 1000) begin
            if (grid_start) gs_bad++;
            go = (go_at >= 0 && acc == go_at && out_valid) ? 1'b1 : 1'b0;
            if (out_valid && !stall_done && stall_cell >= 0 && cell_index == 7'(stall_cell)) begin
                stall_done = 1'b1;
                stall_left = stall_cycles;
                held_dig   = out_digit;
                held_idx   = cell_index;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                if (!out_valid || out_digit !== held_dig || cell_index !== held_idx) stable_bad++;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (cell_index !== 7'(acc)) idx_bad++;
                if (acc < 81 && out_digit !== exp_dig[acc]) dig_bad++;
                if (out_last) last_cnt++;
                if (out_last !== (acc == 80)) last_bad++;
                if (stall_cycles == 0 && last_hs >= 0 && cyc - last_hs != 2) gap_bad++;
                last_hs = cyc;
                acc++;
                if (out_last) done = 1'b1;
            end
            tick();
            cyc++;
        end
        go = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_accepted"}, acc, 81);
        chk({tag, "_index_seq"}, idx_bad, 0);
        chk({tag, "_digits"}, dig_bad, 0);
        chk({tag, "_last_count"}, last_cnt, 1);
        chk({tag, "_last_pos"}, last_bad, 0);
        chk({tag, "_gap2"}, gap_bad, 0);
        chk({tag, "_stall_stable"}, stable_bad, 0);
        chk({tag, "_no_start"}, gs_bad, 0);
        chk({tag, "_solved"}, solved, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_valid_after"}, out_valid, 0);
        chk({tag, "_index_after"}, cell_index, 0);
    endtask

    initial begin
        int vseen;
        int cyc;
        init_cells();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_grid_start", grid_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_solved", solved, 0);
        chk("rst_failed", failed, 0);
        chk("rst_bad_value", bad_value, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_cell_index", cell_index, 0);
        chk("rst_out_digit", out_digit, 0);
        chk("rst_out_last", out_last, 0);
        reset = 1'b1;
        tick();

        // Success with ready high; cell 4 holds 9'b000010000 -> digit 5
        chk("cell4_exp", {28'd0, exp_dig[4]}, 5);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("kick_pulse", grid_start, 1);
        chk("kick_busy", busy, 1);
        tick();
        chk("kick_one_cycle", grid_start, 0);
        repeat (9) tick();
        chk("wait_no_valid", out_valid, 0);
        success = 1'b1;
        collect("run1", -1, 0, -1);
        success = 1'b0;

        // Failure in WAIT, then go clears failed
        start_run();
        failure = 1'b1;
        tick();
        failure = 1'b0;
        chk("fail_failed", failed, 1);
        chk("fail_solved_cleared", solved, 0);
        chk("fail_busy", busy, 0);
        vseen = 0;
        repeat (4) begin
            if (out_valid) vseen++;
            tick();
        end
        chk("fail_no_valid", vseen, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_clears_failed", failed, 0);
        tick();

        // Simultaneous success and failure: failure wins
        success = 1'b1;
        failure = 1'b1;
        tick();
        success = 1'b0;
        failure = 1'b0;
        chk("both_failed", failed, 1);
        chk("both_solved", solved, 0);
        chk("both_busy", busy, 0);
        tick();
        chk("both_no_valid", out_valid, 0);

        // Backpressure at cell 40 for 7 cycles; go pulsed during SEND is ignored
        start_run();
        success = 1'b1;
        tick();
        success = 1'b0;
        collect("bp", 40, 7, 20);

        // Corrupt cells: 12 multi-hot, 13 zero-hot -> digit 0, bad_value sticky
        cells[12]   = 9'b000000011;
        cells[13]   = 9'b000000000;
        exp_dig[12] = 4'd0;
        exp_dig[13] = 4'd0;
        start_run();
        chk("bad_before", bad_value, 0);
        success = 1'b1;
        tick();
        success = 1'b0;
        collect("bad", -1, 0, -1);
        chk("bad_set", bad_value, 1);
        repeat (3) tick();
        chk("bad_sticky", bad_value, 1);
        init_cells();

        // Reset low mid-stream at cell 30
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_clears_bad", bad_value, 0);
        tick();
        success = 1'b1;
        tick();
        success = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && cell_index == 7'd30) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("reach_cell30", cell_index, 30);
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_index", cell_index, 0);
        chk("arst_digit", out_digit, 0);
        chk("arst_grid_start", grid_start, 0);
        #3;
        reset = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_grid_start", grid_start, 0);

`ifdef SOLVE_TIMEOUT_EN
        // Timeout 50 cycles after entering WAIT
        start_run();
        repeat (49) tick();
        chk("tmo_not_yet", failed, 0);
        chk("tmo_busy_wait", busy, 1);
        tick();
        chk("tmo_failed", failed, 1);
        chk("tmo_timed_out", timed_out, 1);
        chk("tmo_busy", busy, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("tmo_cleared", timed_out, 0);
        tick();
        success = 1'b1;
        tick();
        success = 1'b0;
        collect("tmo_run", -1, 0, -1);
        chk("tmo_run_timed_out", timed_out, 0);
`else
        // Without the timeout feature WAIT persists
        start_run();
        repeat (60) tick();
        chk("no_tmo_busy", busy, 1);
        chk("no_tmo_failed", failed, 0);
        chk("no_tmo_timed_out", timed_out, 0);
        failure = 1'b1;
        tick();
        failure = 1'b0;
        chk("no_tmo_fail_exit", failed, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
